// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI responder.
package spi_pkg;

  localparam int SPI_WIDTH       = 16;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

  // Bit counter must hold the value WIDTH itself, not just 0..WIDTH-1.
  function automatic int spi_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer for one async input, plus an extra flop for edge detection.
// Flops reset to 1 so an idle-high line produces no edge after reset.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_slv16.sv
// Mode-0 SPI responder: oversamples SS_n/SCLK/MOSI, returns tx_data on MISO.
// Optional SPI_SLV_FRAME_CHK_EN adds frame_err for short/long frames.
module spi_slv16
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy
`ifdef SPI_SLV_FRAME_CHK_EN
  ,
  output logic             frame_err
`endif
);

  localparam int                CNT_W = spi_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(WIDTH);

  spi_slv_state_t   state, state_d;
  logic [WIDTH-1:0] tx_shft, rx_shft;
  logic [CNT_W-1:0] bitcnt;

  logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_sync;
  logic ss_level_unused, sclk_level_unused, mosi_rise_unused, mosi_fall_unused;
  logic load_tx, shift_rx, shift_tx, frame_end;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (SS_n),
    .sync_out (ss_level_unused),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (SCLK),
    .sync_out (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (MOSI),
    .sync_out (mosi_sync),
    .rise     (mosi_rise_unused),
    .fall     (mosi_fall_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // SS_n rise wins over a same-cycle SCLK edge; SCLK is ignored while idle.
  always_comb begin
    state_d   = state;
    load_tx   = 1'b0;
    shift_rx  = 1'b0;
    shift_tx  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          load_tx = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end else begin
          shift_rx = sclk_rise;
          shift_tx = sclk_fall && (bitcnt != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shft <= '0;
      rx_shft <= '0;
      bitcnt  <= '0;
    end else if (load_tx) begin
      tx_shft <= tx_data;
      bitcnt  <= '0;
    end else begin
      if (shift_rx) begin
        rx_shft <= {rx_shft[WIDTH-2:0], mosi_sync};
        if (bitcnt != FULL) bitcnt <= bitcnt + CNT_W'(1);
      end
      if (shift_tx) tx_shft <= {tx_shft[WIDTH-2:0], 1'b0};
    end
  end

  // A completed frame sets cmd_rdy even if an acknowledge lands in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else if (frame_end && (bitcnt == FULL)) begin
      cmd     <= rx_shft;
      cmd_rdy <= 1'b1;
    end else if (clr_cmd_rdy || load_tx) begin
      cmd_rdy <= 1'b0;
    end
  end

  assign MISO = tx_shft[WIDTH-1];

`ifdef SPI_SLV_FRAME_CHK_EN
  // bitcnt saturates, so a separate flag remembers rises beyond WIDTH.
  logic overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_tx)                         overrun <= 1'b0;
      else if (shift_rx && bitcnt == FULL) overrun <= 1'b1;

      if (frame_end && ((bitcnt != FULL) || overrun)) frame_err <= 1'b1;
      else if (clr_cmd_rdy || load_tx)                 frame_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slv16.sv
// Self-checking bench for spi_slv16: table vectors, corner sequences, random frames.
// Build with SPI_SLV_FRAME_CHK_EN defined to also check frame_err.
module tb_spi_slv16;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI, MISO, clr_cmd_rdy;
  logic [15:0] tx_data, cmd;
  logic        cmd_rdy;
`ifdef SPI_SLV_FRAME_CHK_EN
  logic        frame_err;
`endif

  spi_slv16 dut (
    .clk         (clk),
    .rst         (rst),
    .SS_n        (SS_n),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .tx_data     (tx_data),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy)
`ifdef SPI_SLV_FRAME_CHK_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: what the master has sent this frame and what the slave should show.
  logic [15:0] exp_cmd;
  logic        exp_rdy, exp_err, exp_miso;
  logic [15:0] cur_tx;
  bit          rx_q[$];

  typedef struct {
    logic [15:0] mosi;
    logic [15:0] tx;
    int          nbits;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[5];

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_cmd"}, 64'(cmd), 64'(exp_cmd));
    checkOutput({tag, "_rdy"}, 64'(cmd_rdy), 64'(exp_rdy));
    checkOutput({tag, "_miso"}, 64'(MISO), 64'(exp_miso));
`ifdef SPI_SLV_FRAME_CHK_EN
    checkOutput({tag, "_ferr"}, 64'(frame_err), 64'(exp_err));
`endif
  endtask

  task automatic startFrame(input logic [15:0] tx);
    tx_data = tx;
    cur_tx  = tx;
    rx_q.delete();
    SS_n     = 1'b0;
    exp_rdy  = 1'b0;
    exp_err  = 1'b0;
    exp_miso = tx[15];
    waitClk(8);
    tx_data = 16'($urandom);
    checkModel("start");
  endtask

  // Master drives MOSI on the falling edge and samples MISO at the rising edge.
  task automatic clockBits(input logic [63:0] data, input int n);
    logic [63:0] got, want;
    int k;
    got  = '0;
    want = '0;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = data[n-1-i];
      waitClk(16);
      SCLK = 1'b1;
      k    = rx_q.size();
      got  = {got[62:0], MISO};
      want = {want[62:0], (k < 16) ? cur_tx[15-k] : 1'b0};
      rx_q.push_back(MOSI);
      waitClk(16);
    end
    checkOutput("miso_bits", got, want);
  endtask

  task automatic endFrame(input bit clr_same);
    int          n;
    logic [15:0] c;
    waitClk(16);
    SS_n = 1'b1;
    n    = rx_q.size();
    c    = '0;
    if (n >= 16) begin
      for (int j = n - 16; j < n; j++) c = {c[14:0], rx_q[j]};
      exp_cmd = c;
      exp_rdy = 1'b1;
    end else if (clr_same) begin
      exp_rdy = 1'b0;
    end
    if (n != 16)       exp_err = 1'b1;
    else if (clr_same) exp_err = 1'b0;
    exp_miso = (n >= 1 && n <= 16) ? cur_tx[16-n] : ((n == 0) ? cur_tx[15] : 1'b0);
    waitClk(2);
    if (clr_same) clr_cmd_rdy = 1'b1;
    waitClk(1);
    clr_cmd_rdy = 1'b0;
    waitClk(1);
    checkModel("end");
  endtask

  task automatic pulseClr();
    clr_cmd_rdy = 1'b1;
    waitClk(1);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    checkModel("clr");
  endtask

  task automatic applyStimulus(input vec_t v);
    startFrame(v.tx);
    clockBits({48'b0, v.mosi}, v.nbits);
    endFrame(1'b0);
    checkOutput("vec_cmd", 64'(cmd), 64'(v.exp_cmd));
    checkOutput("vec_rdy", 64'(cmd_rdy), 64'(v.exp_rdy));
  endtask

  initial begin
    vecs[0] = '{mosi: 16'hA5C3, tx: 16'h3C5A, nbits: 16, exp_cmd: 16'hA5C3, exp_rdy: 1'b1};
    vecs[1] = '{mosi: 16'h0001, tx: 16'h1111, nbits: 16, exp_cmd: 16'h0001, exp_rdy: 1'b1};
    vecs[2] = '{mosi: 16'hFFFF, tx: 16'h8E71, nbits: 16, exp_cmd: 16'hFFFF, exp_rdy: 1'b1};
    vecs[3] = '{mosi: 16'h0155, tx: 16'hC003, nbits: 9,  exp_cmd: 16'hFFFF, exp_rdy: 1'b0};
    vecs[4] = '{mosi: 16'h8001, tx: 16'h7FFE, nbits: 16, exp_cmd: 16'h8001, exp_rdy: 1'b1};

    rst = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    clr_cmd_rdy = 1'b0;
    tx_data = '0;
    cur_tx = '0;
    exp_cmd = '0;
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    exp_miso = 1'b0;
    waitClk(3);
    checkModel("reset");
    rst = 1'b0;
    waitClk(4);
    checkModel("post_reset");

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Acknowledge landing on the same clk as the frame-end set, then alone.
    startFrame(16'h1357);
    clockBits(64'h2468, 16);
    endFrame(1'b1);
    checkOutput("clr_same_rdy", 64'(cmd_rdy), 64'd1);
    pulseClr();
    checkOutput("clr_alone_rdy", 64'(cmd_rdy), 64'd0);

    // Free-running SCLK with SS_n high must not disturb anything.
    for (int i = 0; i < 200; i++) begin
      if (i % 8 == 0) SCLK = ~SCLK;
      MOSI = 1'($urandom);
      waitClk(1);
    end
    SCLK = 1'b1;
    waitClk(8);
    checkModel("idle");
    checkOutput("idle_cmd", 64'(cmd), 64'h2468);
    startFrame(16'h5A5A);
    clockBits(64'h8001, 16);
    endFrame(1'b0);
    checkOutput("cmd_8001", 64'(cmd), 64'h8001);

    // Reset in the middle of a frame.
    startFrame(16'hFFFF);
    clockBits(64'h00AB, 8);
    rst = 1'b1;
    #1;
    checkOutput("rst_cmd", 64'(cmd), 64'h0);
    checkOutput("rst_rdy", 64'(cmd_rdy), 64'h0);
    checkOutput("rst_miso", 64'(MISO), 64'h0);
    exp_cmd = '0;
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    exp_miso = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b1;
    waitClk(3);
    rst = 1'b0;
    waitClk(4);
    checkModel("post_midrst");
    startFrame(16'hBEEF);
    clockBits(64'h1234, 16);
    endFrame(1'b0);
    checkOutput("cmd_1234", 64'(cmd), 64'h1234);

    // Random frames, including short and long ones, with random acknowledges.
    for (int f = 0; f < 12; f++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 24)) : 16;
      startFrame(16'($urandom));
      clockBits({$urandom, $urandom}, n);
      endFrame($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) pulseClr();
      waitClk(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slv16.md
Name: spi_slv16

Overview:
- 16-bit SPI responder (slave) that is the far end of the team's 16-bit SPI master link.
- Mode 0 framing:
  - SS_n is active low.
  - MOSI and MISO are sampled on the SCLK rising edge.
  - MOSI and MISO change on the SCLK falling edge.
  - Data is sent MSB first.
- Oversamples SCLK, SS_n and MOSI in the clk domain. The master runs SCLK = clk/32, so oversampling margin is large.
- Delivers each received 16-bit command with a ready flag, and returns tx_data on MISO in the same frame.

Parameters:
- WIDTH, 16, frame length in bits; also the width of cmd and tx_data.
- SYNC_STAGES, 2, metastability flops on each async input, in front of the edge-detect flop.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- SS_n  input  1  slave select from master, active low, async
- SCLK  input  1  serial clock from master, async
- MOSI  input  1  serial data from master, async
- MISO  output  1  serial data to master
- tx_data  input  WIDTH  response word, captured at frame start
- cmd  output  WIDTH  last complete received word
- cmd_rdy  output  1  set when cmd is updated, sticky until cleared
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy

Behaviour:
- Decided: one clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values: cmd=0, cmd_rdy=0, MISO=0, tx shift=0, rx shift=0, bitcnt=0, state=IDLE, all sync flops=1. Flops set to 1 so SS_n and SCLK read as idle-high with no false edge after reset.
- Synchronizing:
  - SS_n, SCLK and MOSI each pass through SYNC_STAGES flops, plus one extra flop for SS_n and SCLK.
  - Edge detection compares the last two flops: rise = prev 0, now 1; fall = prev 1, now 0.
  - Input-to-detect latency is SYNC_STAGES+1 clks.
- IDLE:
  - All SCLK edges are ignored, since the master's SCLK free-runs between frames.
  - On SS_n fall: tx_shft<=tx_data, bitcnt<=0, then go to ACTIVE.
- ACTIVE:
  - SCLK rise: rx_shft<={rx_shft[WIDTH-2:0],MOSI_sync}, then bitcnt<=bitcnt+1 (saturates at WIDTH).
  - SCLK fall with bitcnt!=0: tx_shft<={tx_shft[WIDTH-2:0],1'b0}.
  - SCLK fall with bitcnt==0 is ignored. This covers the master's front-porch fall before the first rise.
  - SS_n rise:
    - If bitcnt==WIDTH: cmd<=rx_shft and cmd_rdy<=1.
    - Otherwise the frame is discarded; cmd and cmd_rdy are unchanged.
    - Go to IDLE in either case.
- MISO=tx_shft[WIDTH-1] (registered shift output, no tristate).
  - The first bit is valid SYNC_STAGES+2 clks after SS_n falls, well inside the master's 8-clk front porch.
- bitcnt is $clog2(WIDTH)+1 bits wide, so WIDTH itself is representable.
- cmd_rdy:
  - Cleared by clr_cmd_rdy or by the next SS_n fall.
  - If set and clr land in the same clk, set wins.
- Same-clk SS_n rise and SCLK edge: the SS_n rise takes priority, and the SCLK edge is ignored.
- More than WIDTH rises in one frame: extra bits shift into rx_shft; at SS_n rise, cmd holds the last WIDTH bits.
- rst mid-frame: everything returns to reset values. A partially shifted frame is lost.

Optional Feature:
- Macro SPI_SLV_FRAME_CHK_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err is set at SS_n rise when bitcnt!=WIDTH (both short and long frames).
  - A long frame still updates cmd.
  - frame_err is cleared by clr_cmd_rdy or the next SS_n fall.
- Undefined: no port and no logic; behaviour is otherwise identical.

Decomposition:
- Package spi_pkg: SPI_WIDTH=16 and typedef enum logic {IDLE, ACTIVE} spi_slv_state_t.
- Sub-module spi_sync_edge (parameter STAGES):
  - Ports: clk, rst, async_in, sync_out, rise, fall.
  - Instantiated for SCLK and SS_n.
  - MOSI uses the same module, with rise and fall left unconnected.

Test Plan:
- Master sends cmd 16'hA5C3 while tx_data=16'h3C5A -> slave cmd=16'hA5C3, cmd_rdy=1 within 4 clks of SS_n rise; master rd_data=16'h3C5A.
- Back-to-back frames 16'h0001 then 16'hFFFF, no clr -> cmd_rdy drops at the second SS_n fall, then cmd=16'hFFFF and cmd_rdy=1.
- clr_cmd_rdy pulsed on the same clk as the frame-end set -> cmd_rdy=1. clr_cmd_rdy alone -> cmd_rdy=0 next clk.
- Short frame of 9 SCLK rises, then SS_n high -> cmd unchanged and cmd_rdy stays 0. With SPI_SLV_FRAME_CHK_EN, frame_err=1.
- SCLK toggling for 200 clks with SS_n high, then a frame of 16'h8001 -> no state change while idle; cmd=16'h8001.
- rst asserted after 8 bits of a frame -> cmd=0, cmd_rdy=0, MISO=0 immediately. A following full frame of 16'h1234 -> cmd=16'h1234.
